// File: rtl/iob_native_ram_resp.sv
// iob_native_ram_resp: native-bus (valid/ready) single-port RAM slave with a
// programmable number of wait states and out-of-range error reporting.
//
// Parameters:
//   ADDR_W      - width of the byte address
//   MEM_ADDR_W  - log2 of the RAM depth in 32-bit words
//   WAIT_STATES - extra cycles (0..15) inserted before ready
// Ports:
//   clk     - clock, rising edge
//   resetn  - asynchronous active-low reset
//   valid   - request strobe, held with a stable request until ready
//   address - byte address, bits [1:0] ignored
//   wdata   - write data
//   wstrb   - byte-lane write enables, 4'b0000 = read
//   ready   - single-cycle response strobe
//   rdata   - read data, zero whenever ready is low
//   err     - out-of-range flag, pulses with ready

module iob_native_ram_resp #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MEM_ADDR_W  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int unsigned Depth    = 2 ** MEM_ADDR_W;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_latch;
  logic [ADDR_W-1:0]     r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_mem [Depth];
  logic                  w_in_range;
  logic [MEM_ADDR_W-1:0] w_idx;
  logic                  w_is_write;
  logic                  w_do_write;

  assign w_in_range = ((r_addr >> (MEM_ADDR_W + 2)) == '0);
  assign w_idx      = r_addr[MEM_ADDR_W+1:2];
  assign w_is_write = (r_wstrb != 4'b0000);
  // The RAM is only touched in the response cycle, so an aborted access never writes.
  assign w_do_write = (r_state == StResp) && w_in_range && w_is_write;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_addr  <= address;
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (valid) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = WaitLoad;
          w_state_nxt = (WAIT_STATES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (!valid) begin
          // Initiator withdrew the request: drop it silently.
          w_state_nxt = StIdle;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          // Counter hits zero on this edge, so the response cycle follows immediately.
          if (r_cnt <= 4'd1) begin
            w_state_nxt = StResp;
            w_cnt_nxt   = 4'd0;
          end
        end
      end
      StResp: begin
        // valid is deliberately not sampled here.
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // RAM contents survive reset; no reset on this process.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    ready = (r_state == StResp);
    err   = 1'b0;
    rdata = 32'h0;
    if (ready) begin
      if (!w_in_range) begin
        err   = 1'b1;
        rdata = 32'hDEADBEEF;
      end else if (!w_is_write) begin
        rdata = r_mem[w_idx];
      end
    end
  end

endmodule

// File: tb/tb_iob_native_ram_resp.sv
module tb_iob_native_ram_resp;

  localparam int unsigned AW  = 32;
  localparam int unsigned MAW = 6;
  localparam int unsigned NW  = 2 ** MAW;

  logic        clk;
  logic        resetn;
  logic        va, vb;
  logic [31:0] aa, ab, da, db;
  logic [3:0]  sa, sb;
  logic        ra, rb, ea, eb;
  logic [31:0] rda, rdb;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [NW];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  iob_native_ram_resp #(.ADDR_W(AW), .MEM_ADDR_W(MAW), .WAIT_STATES(1)) u_dut_a (
    .clk    (clk),
    .resetn (resetn),
    .valid  (va),
    .address(aa),
    .wdata  (da),
    .wstrb  (sa),
    .ready  (ra),
    .rdata  (rda),
    .err    (ea)
  );

  iob_native_ram_resp #(.ADDR_W(AW), .MEM_ADDR_W(MAW), .WAIT_STATES(0)) u_dut_b (
    .clk    (clk),
    .resetn (resetn),
    .valid  (vb),
    .address(ab),
    .wdata  (db),
    .wstrb  (sb),
    .ready  (rb),
    .rdata  (rdb),
    .err    (eb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit b, input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    if (b) begin
      vb = v; ab = a; db = d; sb = s;
    end else begin
      va = v; aa = a; da = d; sa = s;
    end
  endtask

  // Reference: a word-indexed array, address range decided by plain arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                output logic [31:0] erd, output logic eer);
    int unsigned idx;
    if (a >= 32'(NW * 4)) begin
      erd = 32'hDEADBEEF;
      eer = 1'b1;
    end else begin
      idx = (a % (NW * 4)) / 4;
      eer = 1'b0;
      if (s == 4'b0000) begin
        erd = mem_m[idx];
      end else begin
        erd = 32'h0;
        for (int l = 0; l < 4; l++) begin
          if (s[l]) mem_m[idx][8*l +: 8] = d[8*l +: 8];
        end
      end
    end
  endfunction

  // Runs one request; inputs of DUT A are scrambled while waiting since they must be ignored.
  task automatic access(input bit b, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic er,
                        output int lat);
    lat = 0;
    rd  = 32'h0;
    er  = 1'b0;
    drive(b, 1'b1, a, d, s);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (b ? rb : ra) begin
        lat = c;
        rd  = b ? rdb : rda;
        er  = b ? eb : ea;
        break;
      end
      if (!b) begin
        aa = $urandom;
        da = $urandom;
        sa = 4'($urandom);
      end
    end
    drive(b, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic txn_a(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] erd, input logic eer);
    logic [31:0] rd;
    logic        er;
    int          lat;
    access(1'b0, a, d, s, rd, er, lat);
    check({nm, " latency"}, 32'(lat), 32'd2);
    check({nm, " rdata"}, rd, erd);
    check({nm, " err"}, {31'b0, er}, {31'b0, eer});
    @(posedge clk);
    #1;
    check({nm, " idle ready/err"}, {30'b0, ra, ea}, 32'h0);
    check({nm, " idle rdata"}, rda, 32'h0);
  endtask

  initial begin
    logic [31:0] erd, prior, rd, r2;
    logic        eer, er;
    int          lat, nrdy, first, second;

    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    resetn = 1'b0;
    #2;
    check("reset outputs A", {30'b0, ra, ea}, 32'h0);
    check("reset rdata A", rda, 32'h0);
    check("reset outputs B", {30'b0, rb, eb}, 32'h0);
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Fill every word so later reads have known contents.
    for (int i = 0; i < int'(NW); i++) begin
      logic [31:0] d;
      d = $urandom;
      model(32'(i * 4), d, 4'hF, erd, eer);
      txn_a("init", 32'(i * 4), d, 4'hF, erd, eer);
    end

    vecs[0] = '{32'h10,       32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[1] = '{32'h10,       32'h0,        4'h0, 32'h11223344, 1'b0};
    vecs[2] = '{32'h10,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[3] = '{32'h10,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[4] = '{32'h100,      32'h0,        4'h0, 32'hDEADBEEF, 1'b1};
    vecs[5] = '{32'h100,      32'hFFFFFFFF, 4'hF, 32'hDEADBEEF, 1'b1};
    vecs[6] = '{32'h80000010, 32'hFFFFFFFF, 4'hF, 32'hDEADBEEF, 1'b1};
    vecs[7] = '{32'h10,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[8] = '{32'h13,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[9] = '{32'h0,        32'h0,        4'h0, 32'h0,        1'b0};
    vecs[9].exp_rdata = mem_m[0];
    for (int i = 0; i < 10; i++) begin
      model(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, erd, eer);
      txn_a($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
            vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Randomized traffic against the reference array.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        a[$urandom_range(MAW + 2, AW - 1)] = 1'b1;
      end else begin
        a = 32'($urandom_range(0, NW * 4 - 1));
      end
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      model(a, d, s, erd, eer);
      txn_a($sformatf("rand%0d", i), a, d, s, erd, eer);
    end

    // valid stays high after ready: the held level is a new request, not a repeat.
    drive(1'b0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF);
    nrdy = 0; first = 0; second = 0; r2 = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (ra) begin
        nrdy++;
        if (nrdy == 1) begin
          first = c;
          drive(1'b0, 1'b1, 32'h30, 32'h0, 4'h0);
        end else if (nrdy == 2) begin
          second = c;
          r2 = rda;
          drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
      end
    end
    model(32'h30, 32'h0BADF00D, 4'hF, erd, eer);
    check("held valid ready count", 32'(nrdy), 32'd2);
    check("held valid first ready", 32'(first), 32'd2);
    check("held valid second ready", 32'(second), 32'd5);
    check("held valid readback", r2, 32'h0BADF00D);

    // valid withdrawn during WAIT: no write, no ready.
    prior = mem_m[9];
    drive(1'b0, 1'b1, 32'h24, ~prior, 4'hF);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nrdy = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (ra) nrdy++;
    end
    check("withdrawn ready count", 32'(nrdy), 32'd0);
    txn_a("withdrawn readback", 32'h24, 32'h0, 4'h0, prior, 1'b0);

    // Reset pulse in the middle of a write.
    prior = mem_m[8];
    drive(1'b0, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF);
    @(posedge clk);
    #1;
    check("mid-access ready before reset", {31'b0, ra}, 32'h0);
    resetn = 1'b0;
    #1;
    check("reset mid-access outputs", {30'b0, ra, ea}, 32'h0);
    check("reset mid-access rdata", rda, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 resetn = 1'b1;
    txn_a("post-reset readback", 32'h20, 32'h0, 4'h0, prior, 1'b0);
    nrdy = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (ra) nrdy++;
    end
    check("post-reset spurious ready", 32'(nrdy), 32'd0);

    // Zero wait states: latency 1, back-to-back reads every second cycle.
    access(1'b1, 32'h8, 32'hCAFE0001, 4'hF, rd, er, lat);
    check("B write latency", 32'(lat), 32'd1);
    check("B write rdata", rd, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 32'h8, 32'h0, 4'h0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("B b2b ready c%0d", c), {31'b0, rb}, 32'(c % 2));
      check($sformatf("B b2b rdata c%0d", c), rdb, (c % 2 == 1) ? 32'hCAFE0001 : 32'h0);
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iob_native_ram_resp.md
IOB_NATIVE_RAM_RESP -- requirements
Module: iob_native_ram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of the native-bus byte address.
REQ-002 SHALL have parameter MEM_ADDR_W, default 10: log2 of the RAM depth in 32-bit words.
REQ-003 SHALL have parameter WAIT_STATES, default 1: legal range 0..15; extra cycles inserted before ready.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port valid, input, 1: the initiator holds this high, with a stable request, until ready.
REQ-007 SHALL have port address, input, ADDR_W: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port wdata, input, 32: write data.
REQ-009 SHALL have port wstrb, input, 4: byte-lane write enables; 4'b0000 means read.
REQ-010 SHALL have port ready, output, 1: single-cycle response strobe.
REQ-011 SHALL have port rdata, output, 32: read data, valid only while ready=1.
REQ-012 SHALL have port err, output, 1: single-cycle pulse coincident with ready on an out-of-range access.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP, encoded as registers.
REQ-014 SHALL, in IDLE with valid=1, latch address, wdata and wstrb, load the wait counter with WAIT_STATES, and go to WAIT (or to RESP when WAIT_STATES=0).
REQ-015 SHALL, in WAIT, decrement the counter each cycle and go to RESP in the cycle after the counter reaches 0.
REQ-016 SHALL assert ready for exactly one cycle in RESP, then return to IDLE unconditionally.
REQ-017 SHALL assert ready exactly WAIT_STATES+1 cycles after the first cycle valid is seen high in IDLE; response latency for WAIT_STATES=0 is 1.
REQ-018 SHALL not sample valid in RESP, so one request never yields two responses.
REQ-019 SHALL accept a new request in the first IDLE cycle after RESP, for back-to-back throughput of one access per WAIT_STATES+2 cycles.
REQ-020 SHALL treat an access as in range when address[ADDR_W-1:MEM_ADDR_W+2] == 0; word index = address[MEM_ADDR_W+1:2].
REQ-021 SHALL, for an in-range write, update only the byte lanes whose wstrb bit is 1, in the RESP cycle, and drive rdata = 32'h0.
REQ-022 SHALL, for an in-range read, drive rdata = the RAM word at the latched index, reflecting all writes completed earlier.
REQ-023 SHALL, for an out-of-range access, leave the RAM unmodified, drive rdata = 32'hDEADBEEF, and pulse err together with ready.
REQ-024 SHALL drive rdata = 32'h0 and err = 0 whenever ready = 0.
REQ-025 SHALL, if valid falls during WAIT (a protocol violation), return to IDLE on the next edge without writing and without asserting ready.
REQ-026 SHALL ignore changes to address, wdata and wstrb after they are latched in IDLE.

Reset
REQ-027 SHALL, while resetn = 0, force state = IDLE, counter = 0, ready = 0, rdata = 32'h0 and err = 0, asynchronously.
REQ-028 SHALL, on reset mid-access, abort the access with no RAM write and no ready; RAM contents are neither cleared nor initialised by reset.
REQ-029 SHALL accept a request in the first rising edge after resetn deasserts.

Verification
REQ-030 Bench SHALL check (WAIT_STATES=1) write 32'h11223344 to 0x10 with wstrb=4'hF, then read 0x10 -> ready in cycle 2 after valid, rdata=32'h11223344, err=0.
REQ-031 Bench SHALL check partial write wstrb=4'b0101 of 32'hAABBCCDD to 0x10, then read 0x10 -> 32'h11BB33DD.
REQ-032 Bench SHALL check a read at address 1<<(MEM_ADDR_W+2) -> ready+err for one cycle, rdata=32'hDEADBEEF, RAM unchanged on read-back.
REQ-033 Bench SHALL check a write with valid held high one cycle after ready (new request) -> exactly one ready per request, no duplicated write.
REQ-034 Bench SHALL check resetn pulsed low during WAIT of a write to 0x20 -> ready stays 0, and a later read of 0x20 returns its prior value.
REQ-035 Bench SHALL check (WAIT_STATES=0) back-to-back reads -> ready every 2nd cycle, latency 1.
